// File: rtl/dac_serial_tx.sv
// Serial DAC transmitter: one 16-bit {CTRL, sample, 0000} frame per accepted sample.
// Optional DAC_DROP_CNT_EN adds a saturating count of refused-sample cycles.
module dac_serial_tx #(
   parameter int unsigned CLK_DIV = 4,
   parameter logic [3:0]  CTRL    = 4'b0100,
   parameter int unsigned GAP     = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] din,
   input  logic       din_valid,
   output logic       din_ready,
   output logic       dac_cs_n,
   output logic       dac_sclk,
   output logic       dac_din,
   output logic       busy
`ifdef DAC_DROP_CNT_EN
   ,
   output logic [7:0] drop_cnt
`endif
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_SHIFT,
      S_END,
      S_GAP
   } state_t;

   localparam logic [7:0] CD_M1  = 8'(CLK_DIV - 1);
   localparam logic [7:0] GAP_M1 = 8'(GAP - 1);

   state_t      state_q;
   logic [15:0] frame_q;
   logic [15:0] frame_d;
   logic [3:0]  bit_q;
   logic [3:0]  bit_d;
   logic [7:0]  ph_q;
   logic [7:0]  ph_d;
   logic        cs_n_q;
   logic        sclk_q;
   logic        dout_q;
   logic        busy_q;

   assign frame_d   = {CTRL, din, 4'b0000};
   assign bit_d     = bit_q - 4'd1;
   assign ph_d      = ph_q + 8'd1;
   assign din_ready = (state_q == S_IDLE) & ~rst;
   assign dac_cs_n  = cs_n_q;
   assign dac_sclk  = sclk_q;
   assign dac_din   = dout_q;
   assign busy      = busy_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         frame_q <= '0;
         bit_q   <= '0;
         ph_q    <= '0;
         cs_n_q  <= 1'b1;
         sclk_q  <= 1'b0;
         dout_q  <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               if (din_valid) begin
                  frame_q <= frame_d;
                  bit_q   <= 4'd15;
                  ph_q    <= '0;
                  state_q <= S_SHIFT;
                  cs_n_q  <= 1'b0;
                  sclk_q  <= 1'b0;
                  dout_q  <= frame_d[15];
                  busy_q  <= 1'b1;
               end
            end
            S_SHIFT: begin
               if (ph_q == CD_M1) begin
                  ph_q <= '0;
                  if (!sclk_q) begin
                     sclk_q <= 1'b1;
                  end else begin
                     // falling edge: advance data so it settles before the next rise
                     sclk_q <= 1'b0;
                     if (bit_q == 4'd0) begin
                        state_q <= S_END;
                     end else begin
                        bit_q  <= bit_d;
                        dout_q <= frame_q[bit_d];
                     end
                  end
               end else begin
                  ph_q <= ph_d;
               end
            end
            S_END: begin
               if (ph_q == CD_M1) begin
                  ph_q    <= '0;
                  cs_n_q  <= 1'b1;
                  dout_q  <= 1'b0;
                  state_q <= S_GAP;
               end else begin
                  ph_q <= ph_d;
               end
            end
            S_GAP: begin
               if (ph_q == GAP_M1) begin
                  ph_q    <= '0;
                  state_q <= S_IDLE;
                  busy_q  <= 1'b0;
               end else begin
                  ph_q <= ph_d;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

`ifdef DAC_DROP_CNT_EN
   logic [7:0] drop_q;

   assign drop_cnt = drop_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         drop_q <= '0;
      end else if (din_valid && !din_ready && drop_q != 8'hFF) begin
         drop_q <= drop_q + 8'd1;
      end
   end
`endif

endmodule

// File: doc/dac_serial_tx.md
Name: dac_serial_tx

Overview:
- Downstream of the waveform sample generator. Takes its 8-bit sample output and sends each accepted sample to an external 3-wire serial DAC (CS_N/SCLK/DIN, 16-bit frame, MSB first).
- One frame per accepted sample. Samples offered while a frame is in flight are refused via valid/ready; the top level decides whether to hold or drop them.
- Sits between the sample generator and the board DAC pins. All logic runs on the 50 MHz system clock.

Parameters:
- CLK_DIV, 4: clk cycles per SCLK half-period; legal range 1..255.
- CTRL, 4'b0100: control nibble placed in frame bits [15:12].
- GAP, 4: clk cycles CS_N is held high between frames; legal range 1..255.

Ports:
- clk  in  1  system clock, 50 MHz
- rst  in  1  synchronous reset, active-high
- din  in  8  sample word from the waveform generator
- din_valid  in  1  sample offered this cycle
- din_ready  out  1  block can accept a sample this cycle
- dac_cs_n  out  1  DAC chip select, active-low
- dac_sclk  out  1  DAC serial clock; DAC samples DIN on SCLK rising edge
- dac_din  out  1  DAC serial data
- busy  out  1  frame in progress (state != IDLE)

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Reset (rst sampled high at a clk edge):
  - state=IDLE; dac_cs_n=1, dac_sclk=0, dac_din=0, busy=0.
  - din_ready=0 while rst is high.
  - All counters cleared.
- All outputs are registered except din_ready = (state==IDLE) & ~rst.
- Frame format: frame[15:0] = {CTRL, din, 4'b0000}, shifted MSB first.
- States: IDLE -> SHIFT -> END -> GAP -> IDLE.
- IDLE:
  - din_ready=1.
  - At the edge where din_valid & din_ready: capture frame, bit counter=15, phase counter=0.
  - Next cycle: state=SHIFT, dac_cs_n=0, dac_din=frame[15], dac_sclk=0.
  - din_valid=0: remain in IDLE; outputs unchanged.
- SHIFT: each bit occupies 2*CLK_DIV cycles.
  - dac_sclk=0 for the first CLK_DIV cycles, 1 for the next CLK_DIV.
  - On the high->low transition, dac_din advances to the next bit and the bit counter decrements.
  - After bit 0's high phase: dac_sclk=0, state=END.
  - dac_din is stable for the full high phase and for CLK_DIV cycles before each rising edge.
  - Exactly 16 rising edges per frame.
- END:
  - dac_sclk=0, dac_cs_n=0 for CLK_DIV cycles.
  - Then dac_cs_n=1, dac_din=0, state=GAP.
- GAP:
  - dac_cs_n=1 for GAP cycles, then IDLE.
- Timing per frame:
  - dac_cs_n is low for exactly 32*CLK_DIV + CLK_DIV cycles.
  - busy is high for 32*CLK_DIV + CLK_DIV + GAP cycles.
  - The earliest next accept is the cycle after busy falls.
- Back-to-back: din_valid held high continuously gives one frame every 33*CLK_DIV + GAP + 1 cycles.
- Refused samples: din_valid while busy has no effect; no sample is queued.
- din is sampled only at the accept edge. Changes to din during a frame do not alter the frame.
- Reset mid-frame: the frame aborts at that edge (outputs go to reset values); no partial completion.
- Counters:
  - Phase counter is 8-bit and wraps to 0 at CLK_DIV-1.
  - Bit counter is 4-bit and is never used past 0.

Optional Feature:
- Macro: DAC_DROP_CNT_EN.
- Defined:
  - Extra output port drop_cnt (out, 8): counts cycles where din_valid=1 & din_ready=0 & rst=0.
  - Saturates at 8'hFF; cleared by rst only.
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- CLK_DIV=2, GAP=4, CTRL=4'b0100, din=8'hA5 pulsed valid 1 cycle -> one frame 16'h4A50 on dac_din at 16 SCLK rising edges; dac_cs_n low 66 cycles; busy high 70 cycles.
- din_valid held high, din=8'h00 then 8'hFF, CLK_DIV=2, GAP=4 -> frames 16'h4000 then 16'h4FF0; accepts 71 cycles apart; no SCLK edge while dac_cs_n is high.
- Mid-frame din change (8'h3C -> 8'hC3 after 10 cycles) -> frame stays 16'h43C0.
- rst asserted at bit 7 of a frame -> next edge: dac_cs_n=1, dac_sclk=0, dac_din=0, busy=0; after rst release, a new frame is accepted in the first cycle valid is high.
- CLK_DIV=1, GAP=1 -> SCLK toggles every cycle; 16 rising edges; dac_cs_n low 33 cycles.
- DAC_DROP_CNT_EN defined, valid held high for 300 busy cycles -> drop_cnt saturates at 8'hFF; rst clears it to 0.
